// File: rtl/bus_arbiter_rr_if.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter_rr_if
// Brief    : Request/response bundle between the bus masters, the round-robin
//            arbiter and the shared slave. Names are from the arbiter's view.
// Revision : 1.0 - initial release
// ============================================================================
interface bus_arbiter_rr_if #(
  parameter int N_MST = 2,
  parameter int ID_W  = 1,
  parameter int DW    = 32,
  parameter int AW    = 32
);
  // Master-facing side
  logic [N_MST-1:0]    i_bus_en;
  logic [N_MST-1:0]    i_wr_rd;
  logic [N_MST*DW-1:0] i_wr_data;
  logic [N_MST*AW-1:0] i_addr;
  logic [N_MST*4-1:0]  i_byte_en;
  logic [N_MST-1:0]    i_atomic;
  logic [N_MST-1:0]    o_ack;
  logic [N_MST-1:0]    o_err;
  logic [N_MST*DW-1:0] o_rd_data;
  // Slave-facing side
  logic                i_ack;
  logic [DW-1:0]       i_rd_data;
  logic                o_bus_en;
  logic                o_wr_en;
  logic [DW-1:0]       o_wr_data;
  logic [AW-1:0]       o_addr;
  logic [3:0]          o_byte_en;
  logic                o_atomic;
  logic [ID_W-1:0]     o_id;
  logic                o_locked;

  // The arbiter is the bus master toward the shared slave
  modport master (
    input  i_bus_en, i_wr_rd, i_wr_data, i_addr, i_byte_en, i_atomic,
    input  i_ack, i_rd_data,
    output o_ack, o_err, o_rd_data,
    output o_bus_en, o_wr_en, o_wr_data, o_addr, o_byte_en, o_atomic, o_id, o_locked
  );

  // Environment view: requesting masters plus the slave model
  modport slave (
    output i_bus_en, i_wr_rd, i_wr_data, i_addr, i_byte_en, i_atomic,
    output i_ack, i_rd_data,
    input  o_ack, o_err, o_rd_data,
    input  o_bus_en, o_wr_en, o_wr_data, o_addr, o_byte_en, o_atomic, o_id, o_locked
  );
endinterface
`default_nettype wire

// File: rtl/bus_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter_rr
// Brief    : N-master to 1-slave round-robin bus arbiter with atomic locking.
//            Optional watchdog enabled by macro ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module bus_arbiter_rr #(
  parameter int N_MST   = 2,
  parameter int ID_W    = 1,
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int TIMEOUT = 255
) (
  input  wire logic          i_clk,
  input  wire logic          i_rst,
  bus_arbiter_rr_if.master   bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_LOCK = 2'd2;

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [ID_W-1:0] r_grant;
  logic [ID_W-1:0] w_grant_nxt;
  logic [ID_W-1:0] r_rr_ptr;
  logic [ID_W-1:0] w_rr_nxt;
  logic [ID_W-1:0] w_pick;
  logic [ID_W-1:0] w_grant_inc;
  logic            w_found;
  int              w_idx;
  logic            w_sel_bus_en;
  logic            w_sel_wr_rd;
  logic            w_sel_atomic;
  logic [DW-1:0]   w_sel_wr_data;
  logic [AW-1:0]   w_sel_addr;
  logic [3:0]      w_sel_be;
  logic            w_timeout;

  // Round-robin scan starting at r_rr_ptr; indices stay below N_MST
  always_comb begin
    w_pick  = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = 0; k < N_MST; k++) begin
      w_idx = int'(r_rr_ptr) + k;
      if (w_idx >= N_MST) w_idx = w_idx - N_MST;
      if (!w_found && bus.i_bus_en[w_idx]) begin
        w_found = 1'b1;
        w_pick  = ID_W'(w_idx);
      end
    end
  end

  assign w_grant_inc = (int'(r_grant) == N_MST - 1) ? '0 : r_grant + 1'b1;

  always_comb begin
    w_sel_bus_en  = 1'b0;
    w_sel_wr_rd   = 1'b0;
    w_sel_atomic  = 1'b0;
    w_sel_wr_data = '0;
    w_sel_addr    = '0;
    w_sel_be      = '0;
    for (int i = 0; i < N_MST; i++) begin
      if (int'(r_grant) == i) begin
        w_sel_bus_en  = bus.i_bus_en[i];
        w_sel_wr_rd   = bus.i_wr_rd[i];
        w_sel_atomic  = bus.i_atomic[i];
        w_sel_wr_data = bus.i_wr_data[i*DW +: DW];
        w_sel_addr    = bus.i_addr[i*AW +: AW];
        w_sel_be      = bus.i_byte_en[i*4 +: 4];
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [15:0] r_cnt;

  // Counter is zero on the first BUSY cycle, so the limit hits on cycle TIMEOUT
  always_ff @(posedge i_clk) begin
    if (!i_rst || r_state != S_BUSY) r_cnt <= '0;
    else if (!bus.i_ack)             r_cnt <= r_cnt + 16'd1;
  end

  assign w_timeout = (r_state == S_BUSY) && w_sel_bus_en && !bus.i_ack &&
                     (r_cnt == 16'(TIMEOUT - 1));
`else
  assign w_timeout = 1'b0;

  if ((TIMEOUT < 1) || (TIMEOUT > 65535)) begin : g_timeout_unused
  end
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state  <= S_IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_rr_ptr <= w_rr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_rr_nxt    = r_rr_ptr;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_grant_nxt = w_pick;
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (bus.i_ack) begin
          if (w_sel_atomic) begin
            w_state_nxt = S_LOCK;
          end else begin
            w_state_nxt = S_IDLE;
            w_rr_nxt    = w_grant_inc;
          end
        end else if (!w_sel_bus_en || w_timeout) begin
          w_state_nxt = S_IDLE;
          w_rr_nxt    = w_grant_inc;
        end
      end
      S_LOCK: begin
        if (w_sel_bus_en) begin
          w_state_nxt = S_BUSY;
        end else if (!w_sel_atomic) begin
          w_state_nxt = S_IDLE;
          w_rr_nxt    = w_grant_inc;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are gated by reset so an aborted transaction never sees an ack
  always_comb begin
    bus.o_ack     = '0;
    bus.o_err     = '0;
    bus.o_rd_data = '0;
    bus.o_bus_en  = 1'b0;
    bus.o_wr_en   = 1'b0;
    bus.o_wr_data = '0;
    bus.o_addr    = '0;
    bus.o_byte_en = '0;
    bus.o_atomic  = 1'b0;
    bus.o_id      = '0;
    bus.o_locked  = 1'b0;
    if (i_rst) begin
      case (r_state)
        S_BUSY: begin
          bus.o_bus_en  = w_sel_bus_en;
          bus.o_wr_en   = w_sel_wr_rd;
          bus.o_wr_data = w_sel_wr_data;
          bus.o_addr    = w_sel_addr;
          bus.o_byte_en = w_sel_be;
          bus.o_atomic  = w_sel_atomic;
          bus.o_id      = r_grant;
          for (int i = 0; i < N_MST; i++) begin
            if (int'(r_grant) == i) begin
              bus.o_ack[i]              = bus.i_ack | w_timeout;
              bus.o_err[i]              = w_timeout;
              bus.o_rd_data[i*DW +: DW] = bus.i_ack ? bus.i_rd_data : '0;
            end
          end
        end
        S_LOCK: begin
          bus.o_locked = 1'b1;
          bus.o_id     = r_grant;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
